window_offset_ctrl: RTL and testbench
=====================================

Name: window_offset_ctrl

Overview:
- Parametrised successor to the fixed-size drawable-region offset logic in the VGA controller.
- Holds the start/end coordinates of a movable window inside the active display area.
- Applies move requests only on frame boundaries, so the picture never tears mid-frame.
- Adds per-axis step units, wrap-or-clamp edge mode, hold-to-repeat, a frame-gated recenter request and wrap/moved status flags. It feeds the pixel-address and blanking logic.

Parameters:
- H_DISP, 640: active horizontal pixels.
- V_DISP, 480: active vertical lines.
- H_WIN, 128: window width in pixels.
- V_WIN, 96: window height in lines.
- H_UNIT, 8: horizontal pixels per step unit.
- V_UNIT, 16: vertical lines per step unit.
- H_W, 10: horizontal coordinate width.
- V_W, 9: vertical coordinate width.
- STEP_W, 4: step input width.
- WRAP_MODE, 1: 1 = wrap around the display edge, 0 = clamp at the display edge.
- REPEAT_FRAMES, 8: frames between repeated moves while a direction is held (value ≥1).

Ports:
- clock  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- frameStart  in  1  one-cycle pulse at start of vertical blanking.
- moveDirection  in  4  level inputs {Right, Left, Down, Up}.
- moveStep  in  STEP_W  step count in units; 0 = no motion.
- recenter  in  1  one-cycle request to return the window to centre.
- posVerStart  out  V_W  top line.
- posVerEnd  out  V_W  bottom line.
- posHorStart  out  H_W  left pixel.
- posHorEnd  out  H_W  right pixel.
- horWrapped  out  1  high when posHorEnd < posHorStart.
- verWrapped  out  1  high when posVerEnd < posVerStart.
- moved  out  1  one-cycle pulse on any coordinate update.

Behaviour:
- Reset (reset low, asynchronous), all values decimal:
  - Window centred: posHorStart = (H_DISP-H_WIN)/2 = 256, posHorEnd = 383; posVerStart = (V_DISP-V_WIN)/2 = 192, posVerEnd = 287.
  - Flags 0, moved 0, FSM in IDLE, recenter pending cleared.
- Elaboration checks:
  - (2^STEP_W-1)*H_UNIT < H_DISP and the same for V; H_WIN ≤ H_DISP, V_WIN ≤ V_DISP; H_DISP < 2^H_W and V_DISP < 2^V_W.
  - Any violation causes a fatal error.
- Effective direction:
  - Left and Right both set gives horizontal 0; Up and Down both set gives vertical 0.
  - Diagonals are allowed; both axes update in the same cycle.
- Delta per axis: moveStep*UNIT, computed at H_W+1 (or V_W+1) bits with no truncation.
- Wrap mode (WRAP_MODE=1):
  - Decrease: start' = start ≥ d ? start-d : start+DISP-d.
  - Increase: start' = start+d < DISP ? start+d : start+d-DISP.
  - End: end' = (start'+WIN-1) mod DISP.
  - Flags are registered with the coordinates.
- Clamp mode (WRAP_MODE=0):
  - start' = max(0, start-d) or min(DISP-WIN, start+d).
  - end' = start'+WIN-1; flags are always 0.
- All updates are registered on the clock edge where frameStart=1. New values are visible the cycle after the pulse, and moved is high for that same single cycle.
- recenter:
  - Sets a pending bit on any cycle; the bit is applied at the next frameStart.
  - When applied: coordinates take their reset values, moves are suppressed that frame, the FSM goes to IDLE and the pending bit clears.
  - A recenter and a frameStart in the same cycle apply in that cycle.
- Repeat FSM (evaluated only when frameStart=1):
  - IDLE: effective direction nonzero and moveStep ≠ 0 → apply the move, latch lastDir, set counter = REPEAT_FRAMES-1, go to HOLD.
  - HOLD, direction 0: go to IDLE with no move.
  - HOLD, direction ≠ lastDir: apply immediately, reload the counter, update lastDir.
  - HOLD, counter = 0: apply and reload.
  - HOLD, otherwise: decrement the counter.
  - REPEAT_FRAMES=1 moves every frame.
- moveStep changes take effect at the next applied move; moveStep=0 never moves, but the FSM still tracks direction.
- Reset asserted mid-frame: immediate return to centre; the first move after release needs a new frameStart.

Decomposition:
- Shared package (globalVariables):
  - Default display and window dimensions, unit sizes.
  - FSM state encoding (IDLE, HOLD).
  - Direction bit indices (UP=0, DOWN=1, LEFT=2, RIGHT=3).
- Natural sub-module: axis_offset_step. It holds the pure combinational single-axis next-start/end/wrap computation, parametrised by DISP, WIN, UNIT, width and WRAP_MODE. It is instantiated twice (horizontal, vertical).
- The top level keeps the FSM, counter, recenter pending bit and output registers.

Test Plan:
- Reset, then 3 frameStart pulses with no input → Hor 256/383, Ver 192/287; moved never high; flags 0.
- Wrap mode, Left held, moveStep=15 (d=120), REPEAT_FRAMES=8:
  - Moves occur at frames 1, 9 and 17: Hor start 136, 16, then 536 with end 23 and horWrapped=1.
  - moved pulses exactly 3 times.
- Clamp mode, Down with step 15 (d=240) → posVerStart 384 (clamped to 480-96), end 479; a repeat stays at 384/479 and moved still pulses.
- Up and Right held together with step 1 → one frame gives Ver 176/271 and Hor 264/391 in the same cycle; Up+Down together gives no vertical change.
- After moving away, pulse recenter mid-frame → no change until the next frameStart, then centre values restored and moved=1; a held direction is not applied that frame.
- Direction switches Left→Right during HOLD → the move applies on that same frameStart, with no repeat wait.
- Assert reset while in HOLD → centre values immediately; the next move needs a frameStart.

Source files
------------

// File: rtl/window_offset_ctrl_pkg.sv
// Shared constants for the movable display window: default geometry,
// repeat-FSM state encoding and direction bit positions.
package window_offset_ctrl_pkg;

  localparam int unsigned DefHDisp = 640;
  localparam int unsigned DefVDisp = 480;
  localparam int unsigned DefHWin  = 128;
  localparam int unsigned DefVWin  = 96;
  localparam int unsigned DefHUnit = 8;
  localparam int unsigned DefVUnit = 16;

  // Repeat FSM encoding, kept as plain constants for older consumers.
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  // Bit positions inside moveDirection.
  localparam int unsigned DirUp    = 0;
  localparam int unsigned DirDown  = 1;
  localparam int unsigned DirLeft  = 2;
  localparam int unsigned DirRight = 3;

  // Start coordinate that centres a window of size win in a display of size disp.
  function automatic int unsigned center_start(input int unsigned disp, input int unsigned win);
    return (disp - win) / 2;
  endfunction

endpackage

// File: rtl/window_offset_ctrl_axis_offset_step.sv
// Single-axis next-position calculator: moves a window start by step*UNIT
// in either direction, wrapping or clamping at the display edge, and derives
// the matching end coordinate and wrap flag. Purely combinational.
module window_offset_ctrl_axis_offset_step #(
  parameter int unsigned DISP      = 640,
  parameter int unsigned WIN       = 128,
  parameter int unsigned UNIT      = 8,
  parameter int unsigned W         = 10,
  parameter int unsigned STEP_W    = 4,
  parameter int unsigned WRAP_MODE = 1
) (
  input  logic [W-1:0]      start,
  input  logic              dec,
  input  logic              inc,
  input  logic [STEP_W-1:0] step,
  output logic [W-1:0]      next_start,
  output logic [W-1:0]      next_end,
  output logic              wrapped
);

  // One extra bit so start+delta and start+DISP never overflow.
  localparam int unsigned WX = W + 1;
  localparam logic [WX-1:0] DispX    = WX'(DISP);
  localparam logic [WX-1:0] WinM1X   = WX'(WIN - 1);
  localparam logic [WX-1:0] MaxStart = WX'(DISP - WIN);
  localparam logic [WX-1:0] UnitX    = WX'(UNIT);

  logic [WX-1:0] delta;
  logic [WX-1:0] start_x;
  logic [WX-1:0] inc_sum;
  logic [WX-1:0] start_n;
  logic [WX-1:0] end_sum;
  logic [WX-1:0] end_n;

  // Next start/end for this axis; dec takes priority though the caller never sets both.
  always_comb begin
    delta   = WX'(step) * UnitX;
    start_x = {1'b0, start};
    inc_sum = start_x + delta;
    start_n = start_x;
    if (WRAP_MODE != 0) begin
      if (dec) begin
        start_n = (start_x >= delta) ? start_x - delta : start_x + DispX - delta;
      end else if (inc) begin
        start_n = (inc_sum < DispX) ? inc_sum : inc_sum - DispX;
      end
    end else begin
      if (dec) begin
        start_n = (start_x >= delta) ? start_x - delta : '0;
      end else if (inc) begin
        start_n = (inc_sum > MaxStart) ? MaxStart : inc_sum;
      end
    end
    end_sum = start_n + WinM1X;
    end_n   = ((WRAP_MODE != 0) && (end_sum >= DispX)) ? end_sum - DispX : end_sum;
    next_start = start_n[W-1:0];
    next_end   = end_n[W-1:0];
    wrapped    = (WRAP_MODE != 0) && (end_n < start_n);
  end

endmodule

// File: rtl/window_offset_ctrl.sv
// Movable window offset controller: holds the window coordinates inside the
// active display, applies moves and recenter requests only on frameStart so
// the picture never tears, and auto-repeats a held direction every
// REPEAT_FRAMES frames.
module window_offset_ctrl
  import window_offset_ctrl_pkg::*;
#(
  parameter int unsigned H_DISP        = DefHDisp,
  parameter int unsigned V_DISP        = DefVDisp,
  parameter int unsigned H_WIN         = DefHWin,
  parameter int unsigned V_WIN         = DefVWin,
  parameter int unsigned H_UNIT        = DefHUnit,
  parameter int unsigned V_UNIT        = DefVUnit,
  parameter int unsigned H_W           = 10,
  parameter int unsigned V_W           = 9,
  parameter int unsigned STEP_W        = 4,
  parameter int unsigned WRAP_MODE     = 1,
  parameter int unsigned REPEAT_FRAMES = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frameStart,
  input  logic [3:0]        moveDirection,
  input  logic [STEP_W-1:0] moveStep,
  input  logic              recenter,
  output logic [V_W-1:0]    posVerStart,
  output logic [V_W-1:0]    posVerEnd,
  output logic [H_W-1:0]    posHorStart,
  output logic [H_W-1:0]    posHorEnd,
  output logic              horWrapped,
  output logic              verWrapped,
  output logic              moved
);

  localparam int unsigned MaxStep = (1 << STEP_W) - 1;
  localparam int unsigned CntW    = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(REPEAT_FRAMES - 1);

  localparam logic [H_W-1:0] HStartRst = H_W'(center_start(H_DISP, H_WIN));
  localparam logic [H_W-1:0] HEndRst   = H_W'(center_start(H_DISP, H_WIN) + H_WIN - 1);
  localparam logic [V_W-1:0] VStartRst = V_W'(center_start(V_DISP, V_WIN));
  localparam logic [V_W-1:0] VEndRst   = V_W'(center_start(V_DISP, V_WIN) + V_WIN - 1);

  // Reject geometries the single-wrap arithmetic cannot handle.
  if (MaxStep * H_UNIT >= H_DISP) begin : g_bad_h_step
    $fatal(1, "window_offset_ctrl: max horizontal step must be below H_DISP");
  end
  if (MaxStep * V_UNIT >= V_DISP) begin : g_bad_v_step
    $fatal(1, "window_offset_ctrl: max vertical step must be below V_DISP");
  end
  if (H_WIN > H_DISP || V_WIN > V_DISP) begin : g_bad_win
    $fatal(1, "window_offset_ctrl: window larger than display");
  end
  if (H_DISP >= (1 << H_W) || V_DISP >= (1 << V_W)) begin : g_bad_width
    $fatal(1, "window_offset_ctrl: display size does not fit coordinate width");
  end
  if (REPEAT_FRAMES < 1) begin : g_bad_repeat
    $fatal(1, "window_offset_ctrl: REPEAT_FRAMES must be at least 1");
  end

  logic [0:0]      state_q, state_d;
  logic [3:0]      last_dir_q, last_dir_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;

  logic [H_W-1:0] hor_start_q, hor_start_d, hor_end_q, hor_end_d;
  logic [V_W-1:0] ver_start_q, ver_start_d, ver_end_q, ver_end_d;
  logic           hor_wrap_q, hor_wrap_d, ver_wrap_q, ver_wrap_d;
  logic           moved_q, moved_d;

  logic [3:0]     eff_dir;
  logic           step_nz;
  logic           apply;
  logic           recentre_now;

  logic [H_W-1:0] h_next_start, h_next_end;
  logic [V_W-1:0] v_next_start, v_next_end;
  logic           h_next_wrap, v_next_wrap;

  // Opposing directions on one axis cancel each other.
  always_comb begin
    eff_dir           = '0;
    eff_dir[DirUp]    = moveDirection[DirUp] & ~moveDirection[DirDown];
    eff_dir[DirDown]  = moveDirection[DirDown] & ~moveDirection[DirUp];
    eff_dir[DirLeft]  = moveDirection[DirLeft] & ~moveDirection[DirRight];
    eff_dir[DirRight] = moveDirection[DirRight] & ~moveDirection[DirLeft];
    step_nz           = |moveStep;
  end

  window_offset_ctrl_axis_offset_step #(
    .DISP      (H_DISP),
    .WIN       (H_WIN),
    .UNIT      (H_UNIT),
    .W         (H_W),
    .STEP_W    (STEP_W),
    .WRAP_MODE (WRAP_MODE)
  ) u_hor_step (
    .start      (hor_start_q),
    .dec        (eff_dir[DirLeft]),
    .inc        (eff_dir[DirRight]),
    .step       (moveStep),
    .next_start (h_next_start),
    .next_end   (h_next_end),
    .wrapped    (h_next_wrap)
  );

  window_offset_ctrl_axis_offset_step #(
    .DISP      (V_DISP),
    .WIN       (V_WIN),
    .UNIT      (V_UNIT),
    .W         (V_W),
    .STEP_W    (STEP_W),
    .WRAP_MODE (WRAP_MODE)
  ) u_ver_step (
    .start      (ver_start_q),
    .dec        (eff_dir[DirUp]),
    .inc        (eff_dir[DirDown]),
    .step       (moveStep),
    .next_start (v_next_start),
    .next_end   (v_next_end),
    .wrapped    (v_next_wrap)
  );

  // Repeat FSM and recenter pending bit; only frameStart advances the FSM.
  always_comb begin
    state_d      = state_q;
    last_dir_d   = last_dir_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q | recenter;
    apply        = 1'b0;
    recentre_now = 1'b0;
    if (frameStart) begin
      if (pend_q || recenter) begin
        recentre_now = 1'b1;
        state_d      = StIdle;
        last_dir_d   = '0;
        pend_d       = 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if ((eff_dir != '0) && step_nz) begin
              apply      = 1'b1;
              last_dir_d = eff_dir;
              cnt_d      = CntReload;
              state_d    = StHold;
            end
          end
          StHold: begin
            if (eff_dir == '0) begin
              state_d = StIdle;
            end else if (eff_dir != last_dir_q || cnt_q == '0) begin
              // Zero step still "applies" so the repeat timing tracks the direction.
              apply      = 1'b1;
              last_dir_d = eff_dir;
              cnt_d      = CntReload;
            end else begin
              cnt_d = cnt_q - CntW'(1);
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // Coordinate, flag and moved next-state selection.
  always_comb begin
    hor_start_d = hor_start_q;
    hor_end_d   = hor_end_q;
    ver_start_d = ver_start_q;
    ver_end_d   = ver_end_q;
    hor_wrap_d  = hor_wrap_q;
    ver_wrap_d  = ver_wrap_q;
    moved_d     = 1'b0;
    if (recentre_now) begin
      hor_start_d = HStartRst;
      hor_end_d   = HEndRst;
      ver_start_d = VStartRst;
      ver_end_d   = VEndRst;
      hor_wrap_d  = 1'b0;
      ver_wrap_d  = 1'b0;
      moved_d     = 1'b1;
    end else if (apply && step_nz) begin
      hor_start_d = h_next_start;
      hor_end_d   = h_next_end;
      ver_start_d = v_next_start;
      ver_end_d   = v_next_end;
      hor_wrap_d  = h_next_wrap;
      ver_wrap_d  = v_next_wrap;
      moved_d     = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      last_dir_q  <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      hor_start_q <= HStartRst;
      hor_end_q   <= HEndRst;
      ver_start_q <= VStartRst;
      ver_end_q   <= VEndRst;
      hor_wrap_q  <= 1'b0;
      ver_wrap_q  <= 1'b0;
      moved_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      hor_start_q <= hor_start_d;
      hor_end_q   <= hor_end_d;
      ver_start_q <= ver_start_d;
      ver_end_q   <= ver_end_d;
      hor_wrap_q  <= hor_wrap_d;
      ver_wrap_q  <= ver_wrap_d;
      moved_q     <= moved_d;
    end
  end

  assign posHorStart = hor_start_q;
  assign posHorEnd   = hor_end_q;
  assign posVerStart = ver_start_q;
  assign posVerEnd   = ver_end_q;
  assign horWrapped  = hor_wrap_q;
  assign verWrapped  = ver_wrap_q;
  assign moved       = moved_q;

endmodule

// File: tb/tb_window_offset_ctrl.sv
// Bench for window_offset_ctrl: a wrap-mode and a clamp-mode instance share
// stimulus; a frame-level model predicts window position, flags and moved.
module tb_window_offset_ctrl;

  localparam int Rep = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_start;
  logic [3:0] dir;
  logic [3:0] step;
  logic       recenter;

  logic [9:0] w_hs, w_he, c_hs, c_he;
  logic [8:0] w_vs, w_ve, c_vs, c_ve;
  logic       w_hw, w_vw, w_mv, c_hw, c_vw, c_mv;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  window_offset_ctrl #(.WRAP_MODE(1), .REPEAT_FRAMES(Rep)) u_wrap (
    .clock(clock), .reset(reset), .frameStart(frame_start), .moveDirection(dir),
    .moveStep(step), .recenter(recenter), .posVerStart(w_vs), .posVerEnd(w_ve),
    .posHorStart(w_hs), .posHorEnd(w_he), .horWrapped(w_hw), .verWrapped(w_vw),
    .moved(w_mv)
  );

  window_offset_ctrl #(.WRAP_MODE(0), .REPEAT_FRAMES(Rep)) u_clamp (
    .clock(clock), .reset(reset), .frameStart(frame_start), .moveDirection(dir),
    .moveStep(step), .recenter(recenter), .posVerStart(c_vs), .posVerEnd(c_ve),
    .posHorStart(c_hs), .posHorEnd(c_he), .horWrapped(c_hw), .verWrapped(c_vw),
    .moved(c_mv)
  );

  // Index 0 = wrap instance, 1 = clamp instance.
  logic [40:0] obs [2];
  always_comb begin
    obs[0] = {w_hs, w_he, w_vs, w_ve, w_hw, w_vw, w_mv};
    obs[1] = {c_hs, c_he, c_vs, c_ve, c_hw, c_vw, c_mv};
  end

  // Frame-level model state.
  int m_hs [2];
  int m_vs [2];
  int m_lh [2];
  int m_lv [2];
  int m_age [2];
  bit m_held [2];
  bit m_pend [2];
  bit m_moved [2];

  function automatic int mv_axis(int s, int delta, int disp, int win, bit wrap);
    int n = s + delta;
    if (wrap) return ((n % disp) + disp) % disp;
    if (n < 0) return 0;
    if (n > disp - win) return disp - win;
    return n;
  endfunction

  function automatic logic [40:0] expv(int m);
    int he = (m == 0) ? (m_hs[m] + 127) % 640 : m_hs[m] + 127;
    int ve = (m == 0) ? (m_vs[m] + 95) % 480 : m_vs[m] + 95;
    logic hw = (he < m_hs[m]);
    logic vw = (ve < m_vs[m]);
    return {10'(m_hs[m]), 10'(he), 9'(m_vs[m]), 9'(ve), hw, vw, m_moved[m]};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_hs[m] = 256; m_vs[m] = 192; m_lh[m] = 0; m_lv[m] = 0; m_age[m] = 0;
      m_held[m] = 0; m_pend[m] = 0; m_moved[m] = 0;
    end
  endtask

  // Predicts the effect of the coming clock edge from the current inputs.
  task automatic model_step(int m);
    int h = (dir[3] ? 1 : 0) - (dir[2] ? 1 : 0);
    int v = (dir[1] ? 1 : 0) - (dir[0] ? 1 : 0);
    m_moved[m] = 0;
    if (recenter) m_pend[m] = 1;
    if (frame_start) begin
      if (m_pend[m]) begin
        m_hs[m] = 256; m_vs[m] = 192; m_held[m] = 0; m_pend[m] = 0; m_moved[m] = 1;
      end else if (h == 0 && v == 0) begin
        m_held[m] = 0;
      end else if (!m_held[m] || h != m_lh[m] || v != m_lv[m] || m_age[m] == Rep - 1) begin
        if (m_held[m] || step != 0) begin
          m_held[m] = 1; m_lh[m] = h; m_lv[m] = v; m_age[m] = 0;
          if (step != 0) begin
            m_hs[m] = mv_axis(m_hs[m], h * int'(step) * 8, 640, 128, m == 0);
            m_vs[m] = mv_axis(m_vs[m], v * int'(step) * 16, 480, 96, m == 0);
            m_moved[m] = 1;
          end
        end
      end else begin
        m_age[m]++;
      end
    end
  endtask

  // One clock of stimulus; called and returns at a negative edge.
  task automatic cyc(input logic fs, input logic rc);
    frame_start = fs;
    recenter = rc;
    for (int m = 0; m < 2; m++) model_step(m);
    @(negedge clock);
    frame_start = 1'b0;
    recenter = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; frame_start = 1'b0; recenter = 1'b0; dir = '0; step = '0;
    model_reset();
    repeat (2) @(negedge clock);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== expv(m)) begin
        errors++;
        $display("FAIL reset_state mode%0d got %h want %h", m, obs[m], expv(m));
      end
    end
    reset = 1'b1;
    for (int f = 0; f < 6; f++) begin
      cyc(f % 2 == 0, 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv(m) || obs[m][0] !== 1'b0) begin
          errors++;
          $display("FAIL idle_frames mode%0d got %h want %h", m, obs[m], expv(m));
        end
      end
    end
  endtask

  task automatic test_hold_left();
    int pulses = 0;
    dir = '0; step = '0;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    dir = 4'b0100; step = 4'd15;
    for (int f = 1; f <= 17; f++) begin
      cyc(1'b1, 1'b0);
      if (w_mv) pulses++;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv(m)) begin
          errors++;
          $display("FAIL hold_left f%0d mode%0d got %h want %h", f, m, obs[m], expv(m));
        end
      end
      if (f == 1 || f == 9 || f == 17) begin
        checks++;
        if (!((f == 1 && w_hs == 10'd136) || (f == 9 && w_hs == 10'd16) ||
              (f == 17 && w_hs == 10'd536 && w_he == 10'd23 && w_hw))) begin
          errors++;
          $display("FAIL hold_left_pos f%0d got %0d/%0d wrap %b", f, w_hs, w_he, w_hw);
        end
      end
      cyc(1'b0, 1'b0);
      if (w_mv) pulses++;
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL hold_left_pulses got %0d want 3", pulses);
    end
  endtask

  task automatic test_clamp_down();
    dir = '0;
    cyc(1'b1, 1'b1);
    dir = 4'b0010; step = 4'd15;
    for (int f = 1; f <= 9; f++) begin
      cyc(1'b1, 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv(m)) begin
          errors++;
          $display("FAIL clamp_down f%0d mode%0d got %h want %h", f, m, obs[m], expv(m));
        end
      end
      if (f == 1 || f == 9) begin
        checks++;
        if (c_vs !== 9'd384 || c_ve !== 9'd479 || c_mv !== 1'b1 || c_vw !== 1'b0) begin
          errors++;
          $display("FAIL clamp_down_pos f%0d got %0d/%0d mv %b want 384/479 mv 1",
                   f, c_vs, c_ve, c_mv);
        end
      end
    end
  endtask

  task automatic test_diagonal();
    dir = '0;
    cyc(1'b1, 1'b1);
    dir = 4'b1001; step = 4'd1;
    cyc(1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== expv(m)) begin
        errors++;
        $display("FAIL diagonal mode%0d got %h want %h", m, obs[m], expv(m));
      end
    end
    checks++;
    if (w_vs !== 9'd176 || w_ve !== 9'd271 || w_hs !== 10'd264 || w_he !== 10'd391) begin
      errors++;
      $display("FAIL diagonal_pos got V %0d/%0d H %0d/%0d want V 176/271 H 264/391",
               w_vs, w_ve, w_hs, w_he);
    end
    dir = 4'b1011;
    cyc(1'b1, 1'b0);
    checks++;
    if (c_vs !== 9'd176 || c_hs !== 10'd272 || c_mv !== 1'b1) begin
      errors++;
      $display("FAIL up_down_cancel got V %0d H %0d want V 176 H 272", c_vs, c_hs);
    end
  endtask

  task automatic test_recenter();
    dir = 4'b1000; step = 4'd3;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== expv(m)) begin
        errors++;
        $display("FAIL recenter_wait mode%0d got %h want %h", m, obs[m], expv(m));
      end
    end
    cyc(1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== expv(m) || obs[m][40:31] !== 10'd256 || obs[m][0] !== 1'b1) begin
        errors++;
        $display("FAIL recenter_apply mode%0d got %h want %h", m, obs[m], expv(m));
      end
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (obs[0] !== expv(0) || w_hs !== 10'd280) begin
      errors++;
      $display("FAIL recenter_next got %h want %h", obs[0], expv(0));
    end
  endtask

  task automatic test_switch();
    dir = '0;
    cyc(1'b1, 1'b1);
    dir = 4'b0100; step = 4'd2;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    dir = 4'b1000;
    cyc(1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== expv(m) || obs[m][40:31] !== 10'd256 || obs[m][0] !== 1'b1) begin
        errors++;
        $display("FAIL switch_dir mode%0d got %h want %h", m, obs[m], expv(m));
      end
    end
  endtask

  task automatic test_reset_hold();
    dir = 4'b0100; step = 4'd2;
    cyc(1'b1, 1'b0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 model_reset();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== expv(m)) begin
        errors++;
        $display("FAIL reset_in_hold mode%0d got %h want %h", m, obs[m], expv(m));
      end
    end
    @(negedge clock);
    reset = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (obs[1] !== expv(1) || c_hs !== 10'd256) begin
      errors++;
      $display("FAIL reset_no_move got %h want %h", obs[1], expv(1));
    end
    cyc(1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== expv(m) || obs[m][40:31] !== 10'd240) begin
        errors++;
        $display("FAIL reset_first_move mode%0d got %h want %h", m, obs[m], expv(m));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) dir = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) step = 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv(m)) begin
          errors++;
          $display("FAIL random c%0d mode%0d got %h want %h", i, m, obs[m], expv(m));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_left();
    test_clamp_down();
    test_diagonal();
    test_recenter();
    test_switch();
    test_reset_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
